// File: rtl/mixer_ctrl_pkg.sv
// Shared address map, default values and init-sequencer states for the voice
// mixer control register bank.
package mixer_ctrl_pkg;

    // Oscillator bank sub-addresses (low nibble of adr)
    localparam logic [3:0] SUB_LVL       = 4'd2;
    localparam logic [3:0] SUB_MOD_OUT   = 4'd3;
    localparam logic [3:0] SUB_FEEDB_OUT = 4'd4;
    localparam logic [3:0] SUB_PAN       = 4'd7;
    localparam logic [3:0] SUB_MOD_IN    = 4'd10;
    localparam logic [3:0] SUB_FEEDB_IN  = 4'd11;

    localparam logic [6:0] COM_VOL  = 7'd1;
    localparam logic [6:0] COM_MIDI = 7'd2;
    localparam logic [6:0] COM_NAME = 7'd16;

    localparam int         LVL_ON   = 'h40;
    localparam int         PAN_C    = 'h40;
    localparam int         VOL_DEF  = 'h40;
    localparam logic [7:0] NAME_PAD = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2
    } init_state_e;

    // Only the first two oscillators of a patch sound by default.
    function automatic int lvl_default(input int osc);
        return (osc < 2) ? LVL_ON : 0;
    endfunction

endpackage

// File: rtl/param_slew.sv
// One slew-limited parameter: the output walks one LSB per tick toward the
// target using a signed compare, so full-scale jumps never produce zipper noise.
module param_slew #(
    parameter int             DW      = 8,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_tick,
    input  logic [DW-1:0] i_target,
    output logic [DW-1:0] o_out
);

    logic [DW-1:0] r_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= RST_VAL;
        end else if (i_tick) begin
            if ($signed(r_out) < $signed(i_target)) begin
                r_out <= r_out + DW'(1);
            end else if ($signed(r_out) > $signed(i_target)) begin
                r_out <= r_out - DW'(1);
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/mixer_ctrl_regs.sv
// Voice mixer control register bank: osc/com/matrix banks with registered
// read-back, slewed level/pan/volume, and a default-restore init sequencer.
//
// state    | meaning
// ST_IDLE  | normal register access, waiting for init_req
// ST_LOAD  | one cycle: osc/com targets and routing back to defaults
// ST_CLEAR | one matrix column + patch-name char restored per cycle
module mixer_ctrl_regs
    import mixer_ctrl_pkg::*;
#(
    parameter int V_OSC    = 4,
    parameter int DW       = 8,
    parameter int N_MAT    = 2,
    parameter int RAMP_DIV = 64
) (
    input  logic                                    i_reg_clk,
    input  logic                                    i_reset_reg_n,
    input  logic [6:0]                              i_adr,
    input  logic                                    i_write,
    input  logic                                    i_read,
    input  logic                                    i_osc_sel,
    input  logic                                    i_com_sel,
    input  logic [N_MAT-1:0]                        i_mat_sel,
    input  logic [DW-1:0]                           i_wr_data,
    output logic [DW-1:0]                           o_rd_data,
    output logic                                    o_rd_valid,
    input  logic                                    i_init_req,
    output logic                                    o_busy,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_lvl,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_pan,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_mod_out,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_feedb_out,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_mod_in,
    output logic [V_OSC-1:0][DW-1:0]                o_osc_feedb_in,
    output logic [DW-1:0]                           o_m_vol,
    output logic [3:0]                              o_midi_ch,
    output logic [N_MAT-1:0][15:0][V_OSC-1:0][DW-1:0] o_mat_buf,
    output logic [15:0][7:0]                        o_patch_name
);

    localparam int TCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    init_state_e r_state, w_state_nxt;
    logic [6:0]  r_idx;
    logic        w_idx_last;
    logic        w_busy;
    logic        w_wr_en;

    logic [TCNT_W-1:0] r_tick_cnt;
    logic              w_tick;

    logic [V_OSC-1:0][DW-1:0] r_lvl_tgt, r_pan_tgt;
    logic [V_OSC-1:0][DW-1:0] r_mod_out, r_feedb_out, r_mod_in, r_feedb_in;
    logic [DW-1:0]            r_vol_tgt;
    logic [3:0]               r_midi_ch;
    logic [N_MAT-1:0][15:0][V_OSC-1:0][DW-1:0] r_mat;
    logic [15:0][7:0]         r_name;
    logic [DW-1:0]            r_rd_data;
    logic                     r_rd_valid;

    logic [2:0]       w_osc_idx;
    logic [3:0]       w_sub;
    logic             w_name_hit;
    logic [N_MAT-1:0] w_mat_hit;
    logic [DW-1:0]    w_rd_mux;

    assign w_osc_idx  = i_adr[6:4];
    assign w_sub      = i_adr[3:0];
    assign w_name_hit = ((i_adr & ~7'h0F) == COM_NAME);
    assign w_idx_last = (r_idx == 7'(16 * V_OSC - 1));
    assign w_wr_en    = i_write && !w_busy && !i_init_req;
    assign w_tick     = (r_tick_cnt == '0);

    // Matrix selects are only considered when neither osc nor com bank is selected.
    always_comb begin
        logic w_taken;
        w_mat_hit = '0;
        w_taken   = i_osc_sel || i_com_sel;
        for (int m = 0; m < N_MAT; m++) begin
            if (i_mat_sel[m] && !w_taken) begin
                w_mat_hit[m] = 1'b1;
                w_taken      = 1'b1;
            end
        end
    end

    always_ff @(posedge i_reg_clk or negedge i_reset_reg_n) begin
        if (!i_reset_reg_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOAD) begin
                r_idx <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_idx <= r_idx + 7'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_init_req) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (w_idx_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_reg_clk or negedge i_reset_reg_n) begin
        if (!i_reset_reg_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= TCNT_W'(RAMP_DIV - 1);
        end else begin
            r_tick_cnt <= r_tick_cnt - TCNT_W'(1);
        end
    end

    always_ff @(posedge i_reg_clk or negedge i_reset_reg_n) begin
        if (!i_reset_reg_n) begin
            for (int o = 0; o < V_OSC; o++) begin
                r_lvl_tgt[o] <= DW'(lvl_default(o));
            end
            r_pan_tgt   <= {V_OSC{DW'(PAN_C)}};
            r_mod_out   <= '0;
            r_feedb_out <= '0;
            r_mod_in    <= '0;
            r_feedb_in  <= '0;
            r_vol_tgt   <= DW'(VOL_DEF);
            r_midi_ch   <= '0;
            r_mat       <= '0;
            r_name      <= {16{NAME_PAD}};
        end else if (r_state == ST_LOAD) begin
            for (int o = 0; o < V_OSC; o++) begin
                r_lvl_tgt[o] <= DW'(lvl_default(o));
            end
            r_pan_tgt   <= {V_OSC{DW'(PAN_C)}};
            r_mod_out   <= '0;
            r_feedb_out <= '0;
            r_mod_in    <= '0;
            r_feedb_in  <= '0;
            r_vol_tgt   <= DW'(VOL_DEF);
            r_midi_ch   <= '0;
        end else if (r_state == ST_CLEAR) begin
            for (int m = 0; m < N_MAT; m++) begin
                for (int o = 0; o < V_OSC; o++) begin
                    if (r_idx[6:4] == 3'(o)) r_mat[m][r_idx[3:0]][o] <= '0;
                end
            end
            r_name[r_idx[3:0]] <= NAME_PAD;
        end else if (w_wr_en) begin
            if (i_osc_sel) begin
                for (int o = 0; o < V_OSC; o++) begin
                    if (w_osc_idx == 3'(o)) begin
                        case (w_sub)
                            SUB_LVL:       r_lvl_tgt[o]   <= i_wr_data;
                            SUB_MOD_OUT:   r_mod_out[o]   <= i_wr_data;
                            SUB_FEEDB_OUT: r_feedb_out[o] <= i_wr_data;
                            SUB_PAN:       r_pan_tgt[o]   <= i_wr_data;
                            SUB_MOD_IN:    r_mod_in[o]    <= i_wr_data;
                            SUB_FEEDB_IN:  r_feedb_in[o]  <= i_wr_data;
                            default: ;
                        endcase
                    end
                end
            end else if (i_com_sel) begin
                if (i_adr == COM_VOL) begin
                    r_vol_tgt <= i_wr_data;
                end else if (i_adr == COM_MIDI) begin
                    r_midi_ch <= i_wr_data[3:0];
                end else if (w_name_hit) begin
                    r_name[i_adr[3:0]] <= 8'(i_wr_data);
                end
            end else begin
                for (int m = 0; m < N_MAT; m++) begin
                    for (int o = 0; o < V_OSC; o++) begin
                        if (w_mat_hit[m] && (w_osc_idx == 3'(o))) r_mat[m][w_sub][o] <= i_wr_data;
                    end
                end
            end
        end
    end

    // Read-back always returns targets, never the ramping outputs.
    always_comb begin
        w_rd_mux = '0;
        if (i_osc_sel) begin
            for (int o = 0; o < V_OSC; o++) begin
                if (w_osc_idx == 3'(o)) begin
                    case (w_sub)
                        SUB_LVL:       w_rd_mux = r_lvl_tgt[o];
                        SUB_MOD_OUT:   w_rd_mux = r_mod_out[o];
                        SUB_FEEDB_OUT: w_rd_mux = r_feedb_out[o];
                        SUB_PAN:       w_rd_mux = r_pan_tgt[o];
                        SUB_MOD_IN:    w_rd_mux = r_mod_in[o];
                        SUB_FEEDB_IN:  w_rd_mux = r_feedb_in[o];
                        default: ;
                    endcase
                end
            end
        end else if (i_com_sel) begin
            if (i_adr == COM_VOL) begin
                w_rd_mux = r_vol_tgt;
            end else if (i_adr == COM_MIDI) begin
                w_rd_mux = DW'(r_midi_ch);
            end else if (w_name_hit) begin
                w_rd_mux = DW'(r_name[i_adr[3:0]]);
            end
        end else begin
            for (int m = 0; m < N_MAT; m++) begin
                for (int o = 0; o < V_OSC; o++) begin
                    if (w_mat_hit[m] && (w_osc_idx == 3'(o))) w_rd_mux = r_mat[m][w_sub][o];
                end
            end
        end
    end

    always_ff @(posedge i_reg_clk or negedge i_reset_reg_n) begin
        if (!i_reset_reg_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_read;
            if (i_read) r_rd_data <= w_rd_mux;
        end
    end

    for (genvar g = 0; g < V_OSC; g++) begin : g_osc_slew
        param_slew #(
            .DW      (DW),
            .RST_VAL (DW'(lvl_default(g)))
        ) u_lvl_slew (
            .i_clk    (i_reg_clk),
            .i_rst_n  (i_reset_reg_n),
            .i_tick   (w_tick),
            .i_target (r_lvl_tgt[g]),
            .o_out    (o_osc_lvl[g])
        );

        param_slew #(
            .DW      (DW),
            .RST_VAL (DW'(PAN_C))
        ) u_pan_slew (
            .i_clk    (i_reg_clk),
            .i_rst_n  (i_reset_reg_n),
            .i_tick   (w_tick),
            .i_target (r_pan_tgt[g]),
            .o_out    (o_osc_pan[g])
        );
    end

    param_slew #(
        .DW      (DW),
        .RST_VAL (DW'(VOL_DEF))
    ) u_vol_slew (
        .i_clk    (i_reg_clk),
        .i_rst_n  (i_reset_reg_n),
        .i_tick   (w_tick),
        .i_target (r_vol_tgt),
        .o_out    (o_m_vol)
    );

    assign o_busy          = w_busy;
    assign o_rd_data       = r_rd_data;
    assign o_rd_valid      = r_rd_valid;
    assign o_osc_mod_out   = r_mod_out;
    assign o_osc_feedb_out = r_feedb_out;
    assign o_osc_mod_in    = r_mod_in;
    assign o_osc_feedb_in  = r_feedb_in;
    assign o_midi_ch       = r_midi_ch;
    assign o_mat_buf       = r_mat;
    assign o_patch_name    = r_name;

endmodule

// File: tb/tb_mixer_ctrl_regs.sv
// Directed bench for mixer_ctrl_regs with RAMP_DIV=1 so every cycle is a slew tick.
module tb_mixer_ctrl_regs;

    localparam int V_OSC = 4;
    localparam int DW    = 8;
    localparam int N_MAT = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [6:0]           adr;
    logic                 write, read, osc_sel, com_sel, init_req;
    logic [N_MAT-1:0]     mat_sel;
    logic [DW-1:0]        wr_data;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid, busy;
    logic [V_OSC-1:0][DW-1:0] osc_lvl, osc_pan, mod_out, feedb_out, mod_in, feedb_in;
    logic [DW-1:0]        m_vol;
    logic [3:0]           midi_ch;
    logic [N_MAT-1:0][15:0][V_OSC-1:0][DW-1:0] mat_buf;
    logic [15:0][7:0]     patch_name;

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    localparam logic [127:0] NAME_ALL_PAD = {16{8'h20}};

    mixer_ctrl_regs #(.V_OSC(V_OSC), .DW(DW), .N_MAT(N_MAT), .RAMP_DIV(1)) dut (
        .i_reg_clk       (clk),
        .i_reset_reg_n   (rst_n),
        .i_adr           (adr),
        .i_write         (write),
        .i_read          (read),
        .i_osc_sel       (osc_sel),
        .i_com_sel       (com_sel),
        .i_mat_sel       (mat_sel),
        .i_wr_data       (wr_data),
        .o_rd_data       (rd_data),
        .o_rd_valid      (rd_valid),
        .i_init_req      (init_req),
        .o_busy          (busy),
        .o_osc_lvl       (osc_lvl),
        .o_osc_pan       (osc_pan),
        .o_osc_mod_out   (mod_out),
        .o_osc_feedb_out (feedb_out),
        .o_osc_mod_in    (mod_in),
        .o_osc_feedb_in  (feedb_in),
        .o_m_vol         (m_vol),
        .o_midi_ch       (midi_ch),
        .o_mat_buf       (mat_buf),
        .o_patch_name    (patch_name)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drives one access for a single cycle; returns on the following falling edge.
    task automatic bus(input logic osc, input logic com, input logic [1:0] mat,
                       input logic [6:0] a, input logic [7:0] d, input logic w, input logic r);
        osc_sel = osc; com_sel = com; mat_sel = mat; adr = a; wr_data = d; write = w; read = r;
        @(negedge clk);
        osc_sel = 1'b0; com_sel = 1'b0; mat_sel = '0; write = 1'b0; read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; adr = '0; write = 1'b0; read = 1'b0; osc_sel = 1'b0;
        com_sel = 1'b0; init_req = 1'b0; mat_sel = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_lvl",   osc_lvl, 32'h0000_4040);
        check("rst_pan",   osc_pan, 32'h4040_4040);
        check("rst_vol",   m_vol, 8'h40);
        check("rst_name",  patch_name, NAME_ALL_PAD);
        check("rst_busy",  busy, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_rdata", rd_data, 8'h00);
        check("rst_mat",   |mat_buf, 1'b0);

        // osc1 pan write, read-back of target, then 48-tick ramp
        bus(1, 0, 2'b00, 7'h17, 8'h10, 1, 0);
        bus(1, 0, 2'b00, 7'h17, 8'h00, 0, 1);
        check("pan_rd_data",  rd_data, 8'h10);
        check("pan_rd_valid", rd_valid, 1'b1);
        check("pan_step1",    osc_pan[1], 8'h3F);
        @(negedge clk);
        check("rd_valid_pulse", rd_valid, 1'b0);
        check("rd_data_hold",   rd_data, 8'h10);
        check("pan_step2",      osc_pan[1], 8'h3E);
        repeat (45) @(negedge clk);
        check("pan_step47", osc_pan[1], 8'h11);
        @(negedge clk);
        check("pan_step48", osc_pan[1], 8'h10);
        repeat (4) @(negedge clk);
        check("pan_hold", osc_pan[1], 8'h10);

        // bank select priority
        bus(1, 0, 2'b10, 7'h25, 8'hF3, 1, 0);
        check("prio_osc_over_mat", mat_buf[1][5][2], 8'h00);
        bus(0, 0, 2'b10, 7'h25, 8'hF3, 1, 0);
        check("mat1_write", mat_buf[1][5][2], 8'hF3);
        bus(0, 0, 2'b11, 7'h25, 8'h00, 0, 1);
        check("prio_mat0_rd", rd_data, 8'h00);
        bus(0, 0, 2'b10, 7'h25, 8'h00, 0, 1);
        check("mat1_rd", rd_data, 8'hF3);

        // common bank and routing
        bus(0, 1, 2'b00, 7'h02, 8'h3A, 1, 0);
        check("midi_wr", midi_ch, 4'hA);
        bus(0, 1, 2'b00, 7'h05, 8'h00, 0, 1);
        check("com5_rd", rd_data, 8'h00);
        bus(0, 1, 2'b00, 7'h02, 8'h00, 0, 1);
        check("midi_rd", rd_data, 8'h0A);
        bus(0, 1, 2'b00, 7'h13, 8'h41, 1, 0);
        check("name3_wr", patch_name[3], 8'h41);
        bus(0, 1, 2'b00, 7'h01, 8'h00, 0, 1);
        check("vol_rd", rd_data, 8'h40);
        bus(1, 0, 2'b00, 7'h33, 8'h55, 1, 0);
        check("mod_out3", mod_out, 32'h5500_0000);
        bus(1, 0, 2'b00, 7'h43, 8'h66, 1, 0);
        bus(1, 0, 2'b00, 7'h43, 8'h00, 0, 1);
        check("osc4_rd", rd_data, 8'h00);
        bus(0, 1, 2'b00, 7'h02, 8'h07, 1, 1);
        check("rdw_old", rd_data, 8'h0A);
        check("rdw_new", midi_ch, 4'h7);

        // init sequence with simultaneous write
        bus(0, 0, 2'b01, 7'h3F, 8'h11, 1, 0);
        check("mat0_load", mat_buf[0][15][3], 8'h11);
        init_req = 1'b1; com_sel = 1'b1; adr = 7'h01; wr_data = 8'h7F; write = 1'b1;
        @(negedge clk);
        init_req = 1'b0; com_sel = 1'b0; write = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 2) begin
                check("init_wr_dropped", m_vol, 8'h40);
            end else if (cnt == 3) begin
                check("init_pan_ramps", osc_pan[1], 8'h11);
                init_req = 1'b1;
            end else if (cnt == 4) begin
                init_req = 1'b0;
            end else if (cnt == 5) begin
                com_sel = 1'b1; adr = 7'h02; wr_data = 8'h0F; write = 1'b1;
            end else if (cnt == 6) begin
                write = 1'b0; read = 1'b1;
            end else if (cnt == 7) begin
                read = 1'b0; com_sel = 1'b0;
                check("busy_rd_valid", rd_valid, 1'b1);
                check("busy_rd_data", rd_data, 8'h00);
            end
            @(negedge clk);
        end
        check("busy_len",  cnt, 65);
        check("init_mat",  |mat_buf, 1'b0);
        check("init_midi", midi_ch, 4'h0);
        check("init_name", patch_name, NAME_ALL_PAD);
        check("init_mod",  mod_out, 32'h0);
        check("init_pan",  osc_pan, 32'h4040_4040);
        check("init_vol",  m_vol, 8'h40);

        // reset in the middle of CLEAR
        bus(0, 0, 2'b01, 7'h3F, 8'h11, 1, 0);
        bus(0, 1, 2'b00, 7'h13, 8'h41, 1, 0);
        bus(0, 1, 2'b00, 7'h02, 8'h3A, 1, 0);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_mat",  |mat_buf, 1'b0);
        check("abort_midi", midi_ch, 4'h0);
        check("abort_name", patch_name, NAME_ALL_PAD);
        check("abort_lvl",  osc_lvl, 32'h0000_4040);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus(0, 1, 2'b00, 7'h02, 8'h05, 1, 0);
        check("post_rst_wr", midi_ch, 4'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mixer_ctrl_regs.md
# mixer_ctrl_regs

Parametrised control register bank for the voice mixer. It accepts controller writes from the MIDI decoder and serves synchronous read-back to the register bus. It drives per-oscillator levels and routing, master volume, MIDI channel, N_MAT modulation matrices and the patch name. Level, pan and volume outputs are slew-limited to remove zipper noise. A sequenced init engine restores patch defaults without a reset.

## Interface
- V_OSC, 4, oscillators per voice (1..8)
- DW, 8, signed data width of every parameter
- N_MAT, 2, number of 16×V_OSC modulation matrices (1..4)
- RAMP_DIV, 64, reg_clk cycles per slew step (≥1)

- reg_clk  in  1  register clock; all logic on rising edge
- reset_reg_n  in  1  reset, asynchronous, active-low
- adr  in  7  register address within selected bank
- write / read  in  1 / 1  access strobes, one cycle each
- osc_sel, com_sel  in  1 / 1  oscillator bank / common bank select
- mat_sel  in  N_MAT  matrix bank selects
- wr_data  in  DW  signed write data
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data valid pulse
- init_req  in  1  start default-restore sequence
- busy  out  1  init sequence running
- osc_lvl, osc_pan  out  DW×V_OSC  slewed level / pan
- osc_mod_out, osc_feedb_out, osc_mod_in, osc_feedb_in  out  DW×V_OSC  routing amounts
- m_vol  out  DW  slewed master volume
- midi_ch  out  4  MIDI channel
- mat_buf  out  DW×N_MAT×16×V_OSC  matrix coefficients [m][out][osc]
- patch_name  out  8×16  ASCII name

## Operation
- Select priority: osc_sel > com_sel > mat_sel[0] > … > mat_sel[N_MAT-1].
- Osc bank, address o*16+k:
  - k=2 lvl, k=3 mod_out, k=4 feedb_out, k=7 pan, k=10 mod_in, k=11 feedb_in.
  - Other k, and o ≥ V_OSC: writes ignored, reads 0.
- Com bank:
  - 1 m_vol; 2 midi_ch (wr_data[3:0], read zero-extended); 16..31 patch_name[adr-16].
  - Other addresses read 0.
- Matrix bank m, address osc*16+out: mat_buf[m][out][osc]. osc ≥ V_OSC reads 0.
- Slewed params (osc_lvl, osc_pan, m_vol) each hold a target register. Writes and reads-back use the target.
- Tick counter fires every RAMP_DIV cycles. On each tick, every slewed output moves 1 LSB toward its target using a signed compare. It holds once equal.
- Reset values:
  - osc_lvl target/output 0x40 for osc 0,1, otherwise 0.
  - osc_pan 0x40; m_vol 0x40.
  - All routing, matrix and midi_ch 0; patch_name 0x20.
  - rd_data 0, rd_valid 0, busy 0, tick counter 0.
- Init FSM IDLE→LOAD→CLEAR→IDLE.
  - IDLE: init_req → LOAD.
  - LOAD (1 cycle): all osc/com targets and routing set to reset values; index ← 0.
  - CLEAR: each cycle zeros mat_buf[*][index%16][index/16] and patch_name[index%16] ← 0x20. At index = 16·V_OSC−1 → IDLE.
  - busy is high in LOAD and CLEAR.
  - Slewed outputs ramp to defaults; they do not jump.
- While busy: writes dropped, init_req ignored, reads still served.
- init_req and write in the same cycle: init wins, write dropped.

## Timing
- Write: target/register updates at the sampling edge. Unslewed outputs change 1 cycle after the write strobe.
- Read: rd_data and rd_valid are registered 1 cycle after the read strobe. rd_valid is high for exactly 1 cycle. rd_data holds until the next read.
- Read and write to the same address in the same cycle: read returns the pre-write value.
- Slew: full-scale change 0x80→0x7F takes 255 ticks.
- Init: busy is high for 1+16·V_OSC cycles, starting the cycle after init_req.
- Reset asserted mid-init: immediate abort; all reset values apply asynchronously.

## Structure
- Package mixer_ctrl_pkg:
  - Oscillator sub-address constants (2,3,4,7,10,11).
  - Com addresses (1, 2, 16).
  - Default constants (LVL_ON 0x40, PAN_C 0x40, VOL_DEF 0x40, NAME_PAD 0x20).
  - Init state enum.
- Sub-module param_slew: target in, tick, slewed out, reset value parameter. Instantiated 2·V_OSC+1 times.

## Test plan
- Reset release → osc_lvl {40,40,00,00}, osc_pan all 40, m_vol 40, patch_name all 0x20, busy 0.
- osc_sel write adr 0x17 = 0x10, then read 0x17 → rd_data 0x10 one cycle later. osc_pan[1] reaches 0x10 after 48 ticks (RAMP_DIV=1: 48 cycles).
- mat_sel[1] write adr 0x25 = 0xF3 with osc_sel also high → osc bank takes priority, mat_buf[1][5][2] stays 0. Repeat without osc_sel → mat_buf[1][5][2] = 0xF3.
- Write com adr 2 = 0x3A → midi_ch 0xA. Read com adr 5 → 0.
- Load non-zero matrices, then pulse init_req with a simultaneous write → write dropped. busy high 65 cycles (V_OSC=4). All matrices 0. Writes during busy have no effect.
- Drop reset_reg_n mid-CLEAR → busy 0 immediately, all reset values. Post-release write accepted.
